timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped countdown timer: the responder on the device side of the CPU/device bridge.
- Occupies the DEV0 window: CTRL at 0x7F00, PRESET at 0x7F04, COUNT at 0x7F08.
- Accepts word writes qualified by the bridge's per-device write enable, returns read data combinationally, and raises an interrupt request toward CP0 when the count expires.
- Supports one-shot and auto-reload modes.

Parameters:
- WIDTH, 32, width of PRESET/COUNT/data bus.
- RST_PRESET, 0, reset value of PRESET.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  [31:2]  word address from bridge; only addr[3:2] decoded.
- we  input  1  write strobe, already qualified by bridge hit.
- wd  input  WIDTH  write data.
- rd  output  WIDTH  read data, combinational.
- irq  output  1  interrupt request, registered.

Behaviour:
- Reset (async, rst_n=0): CTRL=0, PRESET=RST_PRESET, COUNT=0, state=IDLE, irq_pending=0. irq=0 and rd reflects the reset registers.
- Register map by addr[3:2]:
  - 0 = CTRL. Bits [3:0] are writable: [0] En, [2:1] Mode, [3] IM. Bits [31:4] read 0.
  - 1 = PRESET, read/write.
  - 2 = COUNT, read-only; writes ignored.
  - 3 = reserved; reads 0, writes ignored.
- rd: pure mux of current register values; zero-cycle read latency.
- Writes: take effect at the clk edge where we=1.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: En=1 -> LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT: En=0 -> IDLE, COUNT holds. Else if COUNT>1, COUNT<=COUNT-1. Else (COUNT is 0 or 1), COUNT<=0, irq_pending<=1, -> INT.
  - INT, Mode==01 (auto-reload): -> LOAD; irq_pending<=0.
  - INT, Mode!=01 (one-shot; modes 10/11 alias to 00): En<=0, -> IDLE; irq_pending stays 1.
- One-shot irq_pending clears on any CPU write to CTRL or PRESET.
- irq = irq_pending & CTRL.IM, registered.
  - Auto-reload: irq is a 1-cycle pulse per period.
  - One-shot: irq is level until software rewrites CTRL/PRESET.
- Latency: with En written at edge E, COUNT=PRESET after E+2 and irq rises after E+PRESET+2 (PRESET>=1). PRESET=0 behaves as PRESET=1: irq rises after E+3.
- Auto-reload period: PRESET+2 cycles per irq pulse.
- Simultaneous CPU write to CTRL and FSM clearing En in INT: the CPU write wins.
- Writing PRESET mid-count: COUNT is unaffected; the new value is used at the next LOAD.
- Writing En=0 during CNT/LOAD: FSM reaches IDLE within 2 cycles and COUNT freezes.
- Rewriting CTRL with En=1 while in CNT does not restart the count.
- Clearing IM masks irq immediately (next edge) but keeps irq_pending.
- Reset asserted mid-count: immediate return to reset values; no irq glitch.

Decomposition:
- Shared package timer_pkg:
  - Address offsets (CTRL_OFS=2'd0, PRESET_OFS=2'd1, COUNT_OFS=2'd2).
  - CTRL bit indices (EN_BIT, MODE_LSB/MSB, IM_BIT).
  - Mode encodings (MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01).
  - State enum (IDLE, LOAD, CNT, INT).
- Single module; no sub-module is natural. Register file and FSM share state too tightly to split.

Test Plan:
- Reset then read: read addr 0x7F00/04/08/0C -> rd=0,0,0,0 (RST_PRESET=0); irq=0.
- One-shot: write PRESET=3, then CTRL=0x9 (En=1, Mode=00, IM=1) -> COUNT reads 3,2,1,0 on successive cycles; irq rises 5 edges after the CTRL write and stays high; CTRL reads 0x8. Writing CTRL=0x8 -> irq falls next edge.
- Auto-reload: PRESET=2, CTRL=0xB -> irq 1-cycle pulses every 4 cycles; COUNT sequence 2,1,0,0(INT),2,...
- Mask/stop: mid-count write CTRL=0x1 (IM=0) -> count completes, irq stays 0. Separate run: write En=0 at COUNT=5 -> COUNT frozen at 5 or 4, never reaches 0, no irq.
- Mid-count PRESET change: PRESET=10, start auto-reload, write PRESET=3 at COUNT=7 -> current period ends normally; next period reloads 3.
- Async reset pulse while COUNT=4 and irq pending -> all outputs 0 immediately; COUNT write attempt (addr 0x7F08, wd=0x55) ignored, reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register
// offsets, CTRL bit positions, mode encodings and the FSM state type.
package timer_pkg;

  // Word offsets decoded from addr[3:2]
  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] PRESET_OFS = 2'd1;
  localparam logic [1:0] COUNT_OFS  = 2'd2;

  // CTRL bit positions
  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int MODE_MSB = 2;
  localparam int IM_BIT   = 3;

  // Mode encodings; 2'b10 and 2'b11 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev_if.sv
// Device-side bus between the CPU/device bridge and the timer.
// The bridge is the master; the timer is the slave.
interface timer_dev_if #(
  parameter int WIDTH = 32
);

  logic [31:2]      addr;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             irq;

  modport master (output addr, output we, output wd, input rd, input irq);
  modport slave  (input addr, input we, input wd, output rd, output irq);

endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// CTRL/PRESET/COUNT live in the DEV0 window; reads are combinational and
// the interrupt request is registered.
module timer_dev
  import timer_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RST_PRESET = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  timer_dev_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [3:0]       ctrl_q,   ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q,  count_d;
  state_e           state_q,  state_d;
  logic             pend_q,   pend_d;
  logic             irq_q,    irq_d;

  logic [1:0]       ofs;
  logic             wr_ctrl;
  logic             wr_preset;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] rd_mux;
  logic             unused_addr;

  assign ofs         = bus.addr[3:2];
  assign unused_addr = ^bus.addr[31:4];
  assign wr_ctrl     = bus.we && (ofs == CTRL_OFS);
  assign wr_preset   = bus.we && (ofs == PRESET_OFS);
  assign en          = ctrl_q[EN_BIT];
  assign mode        = ctrl_q[MODE_MSB:MODE_LSB];

  // Next-state logic: FSM transitions, counter, pending flag and CPU writes
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    state_d  = state_q;
    pend_d   = pend_q;

    // A CPU write to CTRL or PRESET acknowledges a latched one-shot interrupt;
    // a fresh expiry in the same cycle (set below) takes precedence.
    if (wr_ctrl || wr_preset) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else begin
          // Expiry on 1, and PRESET=0 is treated the same as PRESET=1
          count_d = '0;
          pend_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // CPU write to CTRL overrides the FSM's own En clear in INT
    if (wr_ctrl) begin
      ctrl_d = bus.wd[3:0];
    end
    if (wr_preset) begin
      preset_d = bus.wd;
    end

    // Registered request built from next-state values so masking and
    // expiry both show up on the edge where they happen
    irq_d = pend_d & ctrl_d[IM_BIT];
  end

  // State and register update with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      preset_q <= RST_PRESET;
      count_q  <= '0;
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

  // Read mux: zero-latency view of the current register values
  always_comb begin
    rd_mux = '0;
    unique case (ofs)
      CTRL_OFS:   rd_mux = {{(WIDTH-4){1'b0}}, ctrl_q};
      PRESET_OFS: rd_mux = preset_q;
      COUNT_OFS:  rd_mux = count_q;
      default:    rd_mux = '0;
    endcase
  end

  assign bus.rd  = rd_mux;
  assign bus.irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: expected register/irq values are queued
// as stimulus is applied and popped as the DUT is observed.
module tb_timer_dev;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSV  = 32'h0000_7F0C;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] exp_q[$];

  logic [31:0] os_cnt[6]  = '{0, 3, 2, 1, 0, 0};
  logic [31:0] os_irq[6]  = '{0, 0, 0, 0, 1, 1};
  logic [31:0] ar_cnt[10] = '{0, 2, 1, 0, 0, 2, 1, 0, 0, 2};
  logic [31:0] ar_irq[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
  logic [31:0] mp_cnt[11] = '{5, 4, 3, 2, 1, 0, 0, 3, 2, 1, 0};
  logic [31:0] mp_irq[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  timer_dev_if #(.WIDTH(32)) bus ();

  timer_dev #(
    .WIDTH      (32),
    .RST_PRESET (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // Drive one write at the current negedge; returns one negedge later
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a[31:2];
    bus.wd   = d;
    bus.we   = 1'b1;
    @(negedge clk);
    bus.we   = 1'b0;
  endtask

  task automatic rd_at(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a[31:2];
    #1;
    v = bus.rd;
  endtask

  // Push one expectation, observe the register, pop and compare
  task automatic exp_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] v;
    exp_q.push_back(e);
    rd_at(a, v);
    sb_check(tag, v);
  endtask

  task automatic exp_irq(input string tag, input logic e);
    exp_q.push_back({31'b0, e});
    sb_check(tag, {31'b0, bus.irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.wd   = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    exp_rd("rst_ctrl", A_CTRL, 32'h0);
    exp_rd("rst_preset", A_PRE, 32'h0);
    exp_rd("rst_count", A_CNT, 32'h0);
    exp_irq("rst_irq", 1'b0);
    @(negedge clk);
    exp_rd("rst_rsv", A_RSV, 32'h0);

    // CTRL upper bits read zero; reserved and COUNT ignore writes
    wr(A_CTRL, 32'hFFFF_FFF6);
    exp_rd("ctrl_mask", A_CTRL, 32'h6);
    wr(A_CTRL, 32'h0);
    wr(A_RSV, 32'hFFFF_FFFF);
    exp_rd("rsv_write", A_RSV, 32'h0);
    wr(A_CNT, 32'h55);
    exp_rd("cnt_write", A_CNT, 32'h0);

    // One-shot, PRESET=3
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(os_cnt[k]);
      exp_q.push_back(os_irq[k]);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rd_at(A_CNT, v);
      sb_check("os_count", v);
      sb_check("os_irq", {31'b0, bus.irq});
    end
    exp_rd("os_ctrl_en_clr", A_CTRL, 32'h8);
    @(negedge clk);
    exp_irq("os_irq_level", 1'b1);
    wr(A_CTRL, 32'h8);
    exp_irq("os_irq_ack", 1'b0);

    // PRESET=0 behaves like PRESET=1
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    idle(2);
    exp_irq("p0_irq_e2", 1'b0);
    @(negedge clk);
    exp_irq("p0_irq_e3", 1'b1);
    @(negedge clk);
    exp_irq("p0_irq_e4", 1'b1);
    wr(A_CTRL, 32'h0);
    exp_irq("p0_irq_ack", 1'b0);

    // Auto-reload, PRESET=2: pulse every 4 cycles
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(ar_cnt[k]);
      exp_q.push_back(ar_irq[k]);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rd_at(A_CNT, v);
      sb_check("ar_count", v);
      sb_check("ar_irq", {31'b0, bus.irq});
    end
    wr(A_CTRL, 32'h0);
    idle(3);

    // Mask mid-count: count completes, irq stays low
    wr(A_PRE, 32'd4);
    wr(A_CTRL, 32'h9);
    idle(3);
    exp_rd("mask_count_e3", A_CNT, 32'd3);
    wr(A_CTRL, 32'h1);
    exp_rd("mask_count_e4", A_CNT, 32'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_irq("mask_irq", 1'b0);
    end
    exp_rd("mask_count_end", A_CNT, 32'd0);
    exp_rd("mask_ctrl_end", A_CTRL, 32'h0);

    // Stop mid-count at COUNT=5: freezes, never expires
    wr(A_PRE, 32'd8);
    wr(A_CTRL, 32'h9);
    idle(5);
    exp_rd("stop_count_e5", A_CNT, 32'd5);
    wr(A_CTRL, 32'h8);
    for (int k = 0; k < 5; k++) begin
      exp_rd("stop_count_frozen", A_CNT, 32'd4);
      exp_irq("stop_irq", 1'b0);
      @(negedge clk);
    end

    // PRESET rewrite mid-count takes effect at the next reload
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'hB);
    idle(5);
    exp_rd("mp_count_e5", A_CNT, 32'd7);
    wr(A_PRE, 32'd3);
    exp_rd("mp_count_e6", A_CNT, 32'd6);
    exp_rd("mp_preset", A_PRE, 32'd3);
    for (int k = 0; k < 11; k++) begin
      exp_q.push_back(mp_cnt[k]);
      exp_q.push_back(mp_irq[k]);
    end
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      rd_at(A_CNT, v);
      sb_check("mp_count", v);
      sb_check("mp_irq", {31'b0, bus.irq});
    end
    wr(A_CTRL, 32'h0);
    idle(3);

    // Asynchronous reset mid-count
    wr(A_PRE, 32'd6);
    wr(A_CTRL, 32'h9);
    idle(4);
    exp_rd("ar_rst_pre_count", A_CNT, 32'd4);
    rst_n = 1'b0;
    exp_rd("rst_async_count", A_CNT, 32'h0);
    exp_irq("rst_async_irq", 1'b0);
    exp_rd("rst_async_ctrl", A_CTRL, 32'h0);
    exp_rd("rst_async_preset", A_PRE, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr(A_CNT, 32'h55);
    exp_rd("post_rst_cnt_write", A_CNT, 32'h0);
    idle(3);
    exp_rd("post_rst_count_hold", A_CNT, 32'h0);
    exp_irq("post_rst_irq", 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
